// File: rtl/bcd_step_counter.sv
// bcd_step_counter: multi-digit BCD up/down counter advanced by the rising
// edges of a slow step signal that is asynchronous to clk.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rstn      asynchronous active-low reset
//   step_in   asynchronous step signal; one count step per rising edge
//   en        step enable; steps seen while low are dropped
//   up        direction, 1 = increment, 0 = decrement
//   load      synchronous load strobe, wins over a coincident step
//   load_val  BCD load value, digit 0 in [3:0]; digits above 9 load as 0
//   count     registered BCD count, digit 0 in [3:0]
//   tc        registered one-cycle terminal-count pulse
//
// Build option: define BCD_STEP_SATURATE_EN to hold at all-9s / all-0s
// instead of wrapping; tc then pulses on every step blocked at the limit.
module bcd_step_counter #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  step_in,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc
);

  localparam int unsigned W = 4 * DIGITS;

  logic         s1, s2, s3;
  logic         step_c;
  logic [W-1:0] next_c;
  logic [W-1:0] load_clean_c;
  logic         at_limit_c;
  logic         all_nine_c;
  logic         all_zero_c;
  logic         carry_c;
  logic [3:0]   dig_c;
  logic [3:0]   ndig_c;
  logic [3:0]   ldig_c;

  // Two-flop synchronizer plus history flop for rising-edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= step_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step_c = s2 & ~s3;

  // Ripple BCD increment/decrement, limit detection and load sanitising
  always_comb begin
    next_c       = '0;
    load_clean_c = '0;
    all_nine_c   = 1'b1;
    all_zero_c   = 1'b1;
    carry_c      = 1'b1;
    dig_c        = 4'd0;
    ndig_c       = 4'd0;
    ldig_c       = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig_c  = count[4*i +: 4];
      ndig_c = dig_c;
      if (dig_c != 4'd9) all_nine_c = 1'b0;
      if (dig_c != 4'd0) all_zero_c = 1'b0;
      // carry_c doubles as the borrow when counting down
      if (carry_c) begin
        if (up) begin
          if (dig_c == 4'd9) begin
            ndig_c = 4'd0;
          end else begin
            ndig_c  = dig_c + 4'd1;
            carry_c = 1'b0;
          end
        end else begin
          if (dig_c == 4'd0) begin
            ndig_c = 4'd9;
          end else begin
            ndig_c  = dig_c - 4'd1;
            carry_c = 1'b0;
          end
        end
      end
      next_c[4*i +: 4] = ndig_c;

      ldig_c = load_val[4*i +: 4];
      load_clean_c[4*i +: 4] = (ldig_c > 4'd9) ? 4'd0 : ldig_c;
    end
    at_limit_c = up ? all_nine_c : all_zero_c;
  end

  // Count register: load beats step; tc is cleared unless a limit event occurs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count <= load_clean_c;
      end else if (step_c && en) begin
`ifdef BCD_STEP_SATURATE_EN
        if (at_limit_c) begin
          tc <= 1'b1;
        end else begin
          count <= next_c;
        end
`else
        count <= next_c;
        tc    <= at_limit_c;
`endif
      end
    end
  end

endmodule
